performance_counter_reader: RTL and testbench

//  Read-out side of the performance counter block: takes the flattened 48-bit event counter

---
 rtl/performance_counter_reader_if.sv | 36 +++
 rtl/performance_counter_reader.sv | 162 ++++++++++++++++
 tb/tb_performance_counter_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/performance_counter_reader_if.sv
// Register read port and dump stream bundle for performance_counter_reader.
// master = requester/consumer side, slave = reader block.
interface performance_counter_reader_if #(
  parameter int NUM_COUNTERS = 20
);
  localparam int IW = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

  logic          rd_en;
  logic [IW-1:0] rd_index;
  logic          rd_hi;
  logic [31:0]   rd_data;
  logic          rd_data_valid;

  logic          dump_start;
  logic          dump_busy;
  logic          dump_valid;
  logic [31:0]   dump_data;
  logic          dump_last;
  logic          dump_ready;

  modport master (
    output rd_en, rd_index, rd_hi,
    output dump_start, dump_ready,
    input  rd_data, rd_data_valid,
    input  dump_busy, dump_valid,
    input  dump_data, dump_last
  );

  modport slave (
    input  rd_en, rd_index, rd_hi,
    input  dump_start, dump_ready,
    output rd_data, rd_data_valid,
    output dump_busy, dump_valid,
    output dump_data, dump_last
  );
endinterface

// File: rtl/performance_counter_reader.sv
// Counter read-out: 32-bit register port with tear-free high half, plus dump stream.
// Define PERF_DUMP_HEADER_EN to prefix every dump with a header word.
module performance_counter_reader #(
  parameter int NUM_COUNTERS = 20,
  parameter int PRFC_WIDTH   = 48
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_COUNTERS*PRFC_WIDTH-1:0] counter_values,
  performance_counter_reader_if.slave        bus
);

  localparam int IW    = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam int NSLOT = 1 << IW;

`ifdef PERF_DUMP_HEADER_EN
  // 'P' is not a hex digit; F stands in for it in the tag.
  localparam logic [15:0] HDR_TAG = 16'hFC0D;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_CAPTURE,
    S_SEND_LO,
    S_SEND_HI
  } state_t;

  // Unused slots read as zero so any index is a legal select.
  logic [47:0] cnt [NSLOT];

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_COUNTERS) begin : g_in
      assign cnt[g] = counter_values[g*PRFC_WIDTH +: PRFC_WIDTH];
    end else begin : g_out
      assign cnt[g] = '0;
    end
  end

  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   hi_snap_q, hi_snap_d;
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [47:0]   shadow_q, shadow_d;

  logic [IW:0] rd_idx_ext;
  logic        rd_in_range;
  logic        idx_last;

  assign rd_idx_ext  = {1'b0, bus.rd_index};
  assign rd_in_range = rd_idx_ext < (IW+1)'(NUM_COUNTERS);
  assign idx_last    = idx_q == IW'(NUM_COUNTERS - 1);

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    hi_snap_d  = hi_snap_q;
    if (bus.rd_en) begin
      rd_valid_d = 1'b1;
      if (bus.rd_hi) begin
        rd_data_d = {16'h0, hi_snap_q};
      end else if (rd_in_range) begin
        rd_data_d = cnt[bus.rd_index][31:0];
        hi_snap_d = cnt[bus.rd_index][47:32];
      end else begin
        rd_data_d = '0;
        hi_snap_d = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.dump_start) begin
          idx_d = '0;
`ifdef PERF_DUMP_HEADER_EN
          state_d = S_HEADER;
`else
          state_d = S_CAPTURE;
`endif
        end
      end
      S_HEADER: begin
`ifdef PERF_DUMP_HEADER_EN
        if (bus.dump_ready) state_d = S_CAPTURE;
`else
        state_d = S_IDLE;
`endif
      end
      S_CAPTURE: begin
        shadow_d = cnt[idx_q];
        state_d  = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (bus.dump_ready) state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (bus.dump_ready) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_CAPTURE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      hi_snap_q  <= '0;
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      hi_snap_q  <= hi_snap_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.dump_busy     = state_q != S_IDLE;
  assign bus.dump_last     = (state_q == S_SEND_HI) && idx_last;

  always_comb begin
    bus.dump_valid = 1'b0;
    bus.dump_data  = '0;
    unique case (state_q)
`ifdef PERF_DUMP_HEADER_EN
      S_HEADER: begin
        bus.dump_valid = 1'b1;
        bus.dump_data  = {HDR_TAG, 16'(NUM_COUNTERS)};
      end
`endif
      S_SEND_LO: begin
        bus.dump_valid = 1'b1;
        bus.dump_data  = shadow_q[31:0];
      end
      S_SEND_HI: begin
        bus.dump_valid = 1'b1;
        bus.dump_data  = {16'h0, shadow_q[47:32]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_performance_counter_reader.sv
// Scoreboard bench for performance_counter_reader (NUM_COUNTERS=4, plus a
// 5-counter instance whose 3-bit index can address past the last counter).
module tb_performance_counter_reader;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N*48-1:0] cv;
  logic [5*48-1:0] cv5;

  performance_counter_reader_if #(.NUM_COUNTERS(N)) bus ();
  performance_counter_reader_if #(.NUM_COUNTERS(5)) bus5 ();

  performance_counter_reader #(.NUM_COUNTERS(N), .PRFC_WIDTH(48)) dut (
    .clk(clk), .reset(reset), .counter_values(cv), .bus(bus)
  );

  performance_counter_reader #(.NUM_COUNTERS(5), .PRFC_WIDTH(48)) dut5 (
    .clk(clk), .reset(reset), .counter_values(cv5), .bus(bus5)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] rd_q  [$];
  logic [31:0] rd5_q [$];
  logic [32:0] dq    [$];
  logic [31:0] rd_hold, rd5_hold;

  function automatic void check(input string nm,
                                input logic [47:0] act,
                                input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents data.
  always @(negedge clk) begin
    if (reset) begin
      rd_hold  = '0;
      rd5_hold = '0;
    end else begin
      if (bus.rd_data_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 48'd1, 48'd0);
        else begin
          rd_hold = rd_q.pop_front();
          check("rd_data", 48'(bus.rd_data), 48'(rd_hold));
        end
      end else begin
        check("rd_hold", 48'(bus.rd_data), 48'(rd_hold));
      end
      if (bus5.rd_data_valid) begin
        if (rd5_q.size() == 0) check("rd5_unexpected", 48'd1, 48'd0);
        else begin
          rd5_hold = rd5_q.pop_front();
          check("rd5_data", 48'(bus5.rd_data), 48'(rd5_hold));
        end
      end
      if (bus.dump_valid) begin
        if (dq.size() == 0) check("dump_unexpected", 48'd1, 48'd0);
        else begin
          check("dump_word", 48'({bus.dump_last, bus.dump_data}), 48'(dq[0]));
          if (bus.dump_ready) void'(dq.pop_front());
        end
      end
    end
  end

  task automatic rd(input logic [1:0] idx, input logic hi,
                    input logic [31:0] exp);
    @(posedge clk); #1;
    bus.rd_en    = 1'b1;
    bus.rd_index = idx;
    bus.rd_hi    = hi;
    rd_q.push_back(exp);
  endtask

  task automatic rd5(input logic [2:0] idx, input logic hi,
                     input logic [31:0] exp);
    @(posedge clk); #1;
    bus5.rd_en    = 1'b1;
    bus5.rd_index = idx;
    bus5.rd_hi    = hi;
    rd5_q.push_back(exp);
  endtask

  task automatic rd_idle();
    @(posedge clk); #1;
    bus.rd_en  = 1'b0;
    bus5.rd_en = 1'b0;
  endtask

  task automatic push_dump();
    logic [31:0] w [8];
    w = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h0,
          32'hFFFF_FFFF, 32'h0000_FFFF};
`ifdef PERF_DUMP_HEADER_EN
    dq.push_back({1'b0, 32'hFC0D_0004});
`endif
    for (int i = 0; i < 8; i++) dq.push_back({(i == 7), w[i]});
  endtask

  task automatic start_dump();
    @(posedge clk); #1 bus.dump_start = 1'b1;
    @(posedge clk); #1 bus.dump_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.dump_busy) break;
    end
    check(nm, 48'(k < 200), 48'd1);
  endtask

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 50 && dq.size() != 0; k++) @(negedge clk);
    check(nm, 48'(dq.size()), 48'd0);
  endtask

  initial begin
    int bcnt;
    int it;
    reset = 1'b1;
    cv = '0; cv5 = '0;
    bus.rd_en = 0; bus.rd_index = 0; bus.rd_hi = 0;
    bus.dump_start = 0; bus.dump_ready = 0;
    bus5.rd_en = 0; bus5.rd_index = 0; bus5.rd_hi = 0;
    bus5.dump_start = 0; bus5.dump_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_rd_valid", 48'(bus.rd_data_valid), 48'd0);
    check("rst_rd_data",  48'(bus.rd_data), 48'd0);
    check("rst_busy",     48'(bus.dump_busy), 48'd0);
    check("rst_dvalid",   48'(bus.dump_valid), 48'd0);
    check("rst_dlast",    48'(bus.dump_last), 48'd0);
    check("rst_ddata",    48'(bus.dump_data), 48'd0);

    // Register port: low read snapshots the high half.
    cv[0*48 +: 48] = 48'hAAAA_1111_2222;
    cv[1*48 +: 48] = 48'hBBBB_3333_4444;
    cv[2*48 +: 48] = 48'h1234_89AB_CDEF;
    rd(2'd2, 1'b0, 32'h89AB_CDEF);
    rd_idle();
    cv[2*48 +: 48] = 48'h5555_0000_0000;
    rd(2'd3, 1'b1, 32'h0000_1234);
    rd(2'd0, 1'b0, 32'h1111_2222);
    rd(2'd1, 1'b0, 32'h3333_4444);
    rd(2'd0, 1'b1, 32'h0000_BBBB);
    rd(2'd2, 1'b0, 32'h0000_0000);
    rd(2'd2, 1'b1, 32'h0000_5555);
    rd_idle();
    repeat (2) @(posedge clk);

    // Out-of-range index on the 5-counter instance.
    cv5[1*48 +: 48] = 48'hABCD_0000_0001;
    rd5(3'd1, 1'b0, 32'h0000_0001);
    rd5(3'd1, 1'b1, 32'h0000_ABCD);
    rd5(3'd5, 1'b0, 32'h0000_0000);
    rd5(3'd0, 1'b1, 32'h0000_0000);
    rd_idle();
    repeat (2) @(posedge clk);

    // Dump with ready held high.
    cv[0*48 +: 48] = 48'h1;
    cv[1*48 +: 48] = 48'h2;
    cv[2*48 +: 48] = 48'h3;
    cv[3*48 +: 48] = 48'hFFFF_FFFF_FFFF;
    bus.dump_ready = 1'b1;
    push_dump();
    start_dump();
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.dump_busy) break;
      bcnt++;
    end
`ifdef PERF_DUMP_HEADER_EN
    check("busy_cycles", 48'(bcnt), 48'd13);
`else
    check("busy_cycles", 48'(bcnt), 48'd12);
`endif
    drain("dump1_drain");

    // Backpressure, stray starts and a concurrent register read.
    push_dump();
    for (it = 0; it < 300; it++) begin
      @(posedge clk); #1;
      bus.dump_start = 1'b0;
      bus.rd_en      = 1'b0;
      if (it > 1 && !bus.dump_busy) break;
      bus.dump_ready = 1'($urandom_range(0, 1));
      if (it == 0 || it % 5 == 2) bus.dump_start = 1'b1;
      if (it == 3) begin
        bus.rd_en    = 1'b1;
        bus.rd_index = 2'd3;
        bus.rd_hi    = 1'b0;
        rd_q.push_back(32'hFFFF_FFFF);
      end
    end
    check("bp_finished", 48'(it < 300), 48'd1);
    bus.dump_ready = 1'b1;
    drain("dump2_drain");
    repeat (3) @(posedge clk);

    // Reset in the middle of a dump.
    push_dump();
    start_dump();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    dq.delete();
    @(negedge clk);
    check("midrst_dvalid", 48'(bus.dump_valid), 48'd0);
    check("midrst_busy",   48'(bus.dump_busy), 48'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("postrst_dvalid", 48'(bus.dump_valid), 48'd0);
    check("postrst_busy",   48'(bus.dump_busy), 48'd0);
    check("postrst_rdv",    48'(bus.rd_data_valid), 48'd0);
    push_dump();
    start_dump();
    wait_idle("dump3_idle");
    drain("dump3_drain");

    repeat (3) @(posedge clk);
    check("rdq_empty", 48'(rd_q.size() + rd5_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
